wb_write_arbiter: RTL
=====================

Name: wb_write_arbiter

Overview:
- Writeback stage directly upstream of the 16x32 register file write port A; it alone drives WEN_A/WA_A/W_DA.
- Merges two result sources: single-cycle ALU results, and load return data from the memory interface, which can arrive as back-to-back words for LDR, POP or LDMIA.
- Buffers load returns in a small FIFO and enforces program-order writes to the same register.
- Exports a pending-register mask so decode can interlock.

Parameters:
- FIFO_DEPTH, 4, load return buffer entries; power of 2, minimum 2.
- DW, 32, data width.
- AW, 4, register address width (16 registers).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- ALU_VLD  in  1  ALU result valid.
- ALU_RDY  out  1  ALU result accepted this cycle when high with ALU_VLD.
- ALU_WA  in  4  ALU destination register.
- ALU_WD  in  32  ALU result.
- LD_VLD  in  1  load data word valid.
- LD_RDY  out  1  load word accepted when high with LD_VLD.
- LD_WA  in  4  load destination register.
- LD_WD  in  32  load data.
- WEN_A  out  1  register file write enable, active-low, registered.
- WA_A  out  4  register file write address, registered.
- W_DA  out  32  register file write data, registered.
- BUSY_MASK  out  16  bit r high iff a valid FIFO entry targets register r.
- FIFO_CNT  out  3  current FIFO occupancy (0..FIFO_DEPTH).

Behaviour:
- Reset (RST low, asynchronous):
  - WEN_A=1, WA_A=0, W_DA=0.
  - FIFO empty; read and write pointers = 0; FIFO_CNT=0; BUSY_MASK=0.
  - LD_RDY=1; ALU_RDY=1.
  - A reset asserted mid-burst discards all buffered words; no write is issued.
- LD_RDY = (FIFO_CNT < FIFO_DEPTH). Combinational from count only; no same-cycle pop credit.
- ld_acc = LD_VLD & LD_RDY.
- ALU_RDY is low if any of the following holds, else high:
  - BUSY_MASK[ALU_WA] is set. The older load must commit first.
  - ld_acc and LD_WA==ALU_WA. The same-cycle load is program-older.
  - FIFO_CNT==FIFO_DEPTH. Forced drain; prevents load starvation.
- alu_acc = ALU_VLD & ALU_RDY.
- Per-cycle write selection, in priority order:
  - (1) alu_acc: write ALU_WA/ALU_WD.
  - (2) FIFO non-empty: pop head, write its address and data.
  - (3) FIFO empty and ld_acc: cut-through; write LD_WA/LD_WD directly, nothing pushed.
  - (4) Otherwise WEN_A=1 next cycle; WA_A and W_DA hold their previous values.
- Push: ld_acc and not cut-through. When (1) wins and a load also arrives, the load is pushed even if the FIFO is empty.
- Simultaneous push and pop: count unchanged; entries still leave in arrival order.
- Pointers wrap modulo FIFO_DEPTH.
- Latency: an accepted input appears on the WEN_A/WA_A/W_DA outputs on the next CLK edge (1 cycle). The register file captures it one edge later.
- At most one register file write per cycle. Every accepted word is written exactly once, in acceptance order per register.
- BUSY_MASK: OR over valid entries of one-hot(WA). A cut-through load never sets a bit.
- Register 15 receives no special treatment here.

Optional Feature:
- Macro WB_ARB_STAT_EN.
- Defined:
  - Adds outputs ALU_STALL_CNT[15:0] and LD_BP_CNT[15:0].
  - Both are saturating counters at 16'hFFFF.
  - ALU_STALL_CNT increments on cycles with ALU_VLD & ~ALU_RDY.
  - LD_BP_CNT increments on cycles with LD_VLD & ~LD_RDY.
  - Both clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package wb_pkg holds:
  - Constants WB_DW=32, WB_AW=4, WB_NREG=16, WB_FIFO_DEPTH=4.
  - Typedef wb_req_t {addr[3:0], data[31:0]}.
  - Write-source enum {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_FIFO, WB_SRC_LD}.
- One sub-module, wb_load_fifo:
  - Synchronous FIFO with push, pop, head, count, full, empty.
  - Also outputs the per-entry valid address vector used to build BUSY_MASK.
- Arbitration, hazard logic and the output register stay in wb_write_arbiter.

Test Plan:
- Reset, then idle:
  - Stimulus: hold RST low 3 cycles, then release with ALU_VLD=LD_VLD=0.
  - Required: WEN_A=1, WA_A=0, W_DA=0, LD_RDY=1, ALU_RDY=1, FIFO_CNT=0, BUSY_MASK=0.
- ALU write:
  - Stimulus: ALU_VLD=1, ALU_WA=3, ALU_WD=32'h1234_5678 for one cycle.
  - Required: next cycle WEN_A=0, WA_A=3, W_DA=32'h1234_5678; following cycle WEN_A=1.
- Load burst vs ALU:
  - Stimulus: LD_VLD on 4 consecutive cycles (r0..r3, data 32'hA0..A3) while ALU_VLD=1 to r7 throughout.
  - Required: ALU writes r7 each cycle; FIFO_CNT reaches 4; LD_RDY=0; ALU_RDY drops.
  - Required: r0..r3 then drain in order.
- Same-register hazard:
  - Stimulus: FIFO holds r5=32'hDEAD; ALU_VLD to r5 with 32'hBEEF.
  - Required: ALU_RDY=0 until r5 entry written; then r5 is written 32'hBEEF; final order DEAD then BEEF.
- Cut-through and full boundary:
  - Stimulus: load to r2 with empty FIFO and no ALU.
  - Required: WEN_A=0 next cycle, BUSY_MASK stays 0.
  - Stimulus: fill FIFO to 4 with simultaneous push and pop.
  - Required: FIFO_CNT unchanged, no word lost or duplicated.
- Mid-burst reset:
  - Stimulus: assert RST with FIFO_CNT=3.
  - Required: immediate WEN_A=1, FIFO_CNT=0, BUSY_MASK=0; no writes after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter slice: widths, the buffered
// request record, the write-source encoding and a one-hot helper.
package wb_pkg;

  localparam int WB_DW         = 32;
  localparam int WB_AW         = 4;
  localparam int WB_NREG       = 16;
  localparam int WB_FIFO_DEPTH = 4;

  // One pending register-file write: destination register and its data.
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_req_t;

  // Which source drives the register file write port on the next edge.
  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_FIFO,
    WB_SRC_LD
  } wb_src_e;

  // One-hot register mask for a register index.
  function automatic logic [WB_NREG-1:0] wb_onehot(input logic [WB_AW-1:0] idx);
    return WB_NREG'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-return buffer for the writeback arbiter. Entries leave in arrival
// order; pointers wrap modulo DEPTH, so DEPTH must be a power of 2 (>= 2).
// Each slot carries a valid bit so the arbiter can see which registers
// still have a load waiting to commit.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  wb_req_t                          push_req,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH-1:0]                 entry_vld,
  output logic [DEPTH-1:0][WB_AW-1:0]      entry_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_req_t [DEPTH-1:0] mem_q, mem_d;
  logic    [DEPTH-1:0] vld_q, vld_d;
  logic    [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic    [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic    [CW-1:0]    cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy; pop frees the head slot
  // and push fills the tail slot, both may happen in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_req;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards every buffered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Per-slot destination addresses for the pending-register mask.
  always_comb begin
    entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = mem_q[i].addr;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign count     = cnt_q;
  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign entry_vld = vld_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter in front of register file write port A. Merges ALU
// results with load returns (buffered in wb_load_fifo), keeps writes to the
// same register in program order and exports the pending-register mask.
// Optional build macro WB_ARB_STAT_EN adds saturating stall counters
// ALU_STALL_CNT and LD_BP_CNT.
// The buffered request record uses the package widths, so DW/AW are
// expected to stay at WB_DW/WB_AW.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int DW         = WB_DW,
  parameter int AW         = WB_AW
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             ALU_VLD,
  output logic                             ALU_RDY,
  input  logic [AW-1:0]                    ALU_WA,
  input  logic [DW-1:0]                    ALU_WD,
  input  logic                             LD_VLD,
  output logic                             LD_RDY,
  input  logic [AW-1:0]                    LD_WA,
  input  logic [DW-1:0]                    LD_WD,
  output logic                             WEN_A,
  output logic [AW-1:0]                    WA_A,
  output logic [DW-1:0]                    W_DA,
  output logic [WB_NREG-1:0]               BUSY_MASK,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  FIFO_CNT
`ifdef WB_ARB_STAT_EN
  ,
  output logic [15:0]                      ALU_STALL_CNT,
  output logic [15:0]                      LD_BP_CNT
`endif
);

  wb_req_t                             ld_req;
  wb_req_t                             fifo_head;
  logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_cnt;
  logic                                fifo_full;
  logic                                fifo_empty;
  logic [FIFO_DEPTH-1:0]               entry_vld;
  logic [FIFO_DEPTH-1:0][WB_AW-1:0]    entry_addr;
  logic [WB_NREG-1:0]                  busy_mask;

  logic    ld_rdy, ld_acc, alu_rdy, alu_acc;
  logic    fifo_push, fifo_pop;
  wb_src_e src;

  logic          wen_q, wen_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;

  assign ld_req.addr = LD_WA;
  assign ld_req.data = LD_WD;

  wb_load_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RST),
    .push       (fifo_push),
    .push_req   (ld_req),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_cnt),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .entry_vld  (entry_vld),
    .entry_addr (entry_addr)
  );

  // Registers that still have a buffered load waiting to commit.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_vld[i]) begin
        busy_mask = busy_mask | wb_onehot(entry_addr[i]);
      end
    end
  end

  // Load acceptance depends only on occupancy; a same-cycle pop gives no credit.
  assign ld_rdy = ~fifo_full;
  assign ld_acc = LD_VLD & ld_rdy;

  // ALU is held off by an older buffered load to the same register, by a
  // same-cycle load to the same register, and while the buffer is full.
  always_comb begin
    alu_rdy = ~(busy_mask[ALU_WA] | (ld_acc & (LD_WA == ALU_WA)) | fifo_full);
  end

  assign alu_acc = ALU_VLD & alu_rdy;

  // Write source priority: ALU, then buffered load, then cut-through load.
  always_comb begin
    src = WB_SRC_NONE;
    if (alu_acc) begin
      src = WB_SRC_ALU;
    end else if (!fifo_empty) begin
      src = WB_SRC_FIFO;
    end else if (ld_acc) begin
      src = WB_SRC_LD;
    end
  end

  assign fifo_pop  = (src == WB_SRC_FIFO);
  assign fifo_push = ld_acc & (src != WB_SRC_LD);

  // Next value of the registered write port; address and data hold when idle.
  always_comb begin
    wen_d = 1'b1;
    wa_d  = wa_q;
    wd_d  = wd_q;
    case (src)
      WB_SRC_ALU: begin
        wen_d = 1'b0;
        wa_d  = ALU_WA;
        wd_d  = ALU_WD;
      end
      WB_SRC_FIFO: begin
        wen_d = 1'b0;
        wa_d  = fifo_head.addr;
        wd_d  = fifo_head.data;
      end
      WB_SRC_LD: begin
        wen_d = 1'b0;
        wa_d  = LD_WA;
        wd_d  = LD_WD;
      end
      default: begin
        wen_d = 1'b1;
      end
    endcase
  end

  // Registered register-file write port (WEN_A is active-low).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wen_q <= 1'b1;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      wen_q <= wen_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
    end
  end

  assign ALU_RDY   = alu_rdy;
  assign LD_RDY    = ld_rdy;
  assign WEN_A     = wen_q;
  assign WA_A      = wa_q;
  assign W_DA      = wd_q;
  assign BUSY_MASK = busy_mask;
  assign FIFO_CNT  = fifo_cnt;

`ifdef WB_ARB_STAT_EN
  logic [15:0] alu_stall_cnt_q, alu_stall_cnt_d;
  logic [15:0] ld_bp_cnt_q, ld_bp_cnt_d;

  // Saturating counts of refused ALU results and back-pressured load words.
  always_comb begin
    alu_stall_cnt_d = alu_stall_cnt_q;
    ld_bp_cnt_d     = ld_bp_cnt_q;
    if (ALU_VLD && !alu_rdy && (alu_stall_cnt_q != 16'hFFFF)) begin
      alu_stall_cnt_d = alu_stall_cnt_q + 16'd1;
    end
    if (LD_VLD && !ld_rdy && (ld_bp_cnt_q != 16'hFFFF)) begin
      ld_bp_cnt_d = ld_bp_cnt_q + 16'd1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_stall_cnt_q <= '0;
      ld_bp_cnt_q     <= '0;
    end else begin
      alu_stall_cnt_q <= alu_stall_cnt_d;
      ld_bp_cnt_q     <= ld_bp_cnt_d;
    end
  end

  assign ALU_STALL_CNT = alu_stall_cnt_q;
  assign LD_BP_CNT     = ld_bp_cnt_q;
`endif

endmodule
